aes256_key_schedule: RTL and testbench
======================================

Name: aes256_key_schedule

Overview:
- Sequential AES-256 key expansion (FIPS-197).
- Accepts a 256-bit cipher key and produces the 15 × 128-bit round-key chain consumed by aes_decryption and the encryption datapath.
- Computes one 32-bit schedule word per cycle using a single shared 4-byte S-box.
- Presents the chain in encryption order, or reversed for the decryption datapath, selected per key.

Parameters:
- NUM_ROUND_KEYS, 15, round keys produced; fixed for AES-256, width derivations only.
- WORD_W, 32, schedule word width.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous, active-low reset.
- key_v_i  input  1  key valid.
- key_i  input  256  cipher key; word 0 = key_i[255:224].
- decrypt_i  input  1  sampled with the key; 1 = reversed (decryption) chain order.
- ready_o  output  1  block can accept a key.
- key_chain_o  output  1920  round-key chain.
- v_o  output  1  key_chain_o valid.
- yumi_i  input  1  consumer takes the chain; legal only while v_o=1.

Behaviour:
- Reset (reset_i low, any time, including mid-expansion):
  - State → IDLE; ready_o=0 during reset, 1 in the first cycle after release.
  - v_o=0, word counter=0, all 60 word registers and key_chain_o cleared to 0, order flag=0.
- States:
  - IDLE: ready_o=1. key_v_i=1 at edge E0 → load w[0..7] from key_i, latch decrypt_i, counter=8, go to EXPAND.
  - EXPAND: ready_o=0. Each edge writes w[counter] and increments the counter. The edge writing w[59] (E52) moves the block to DONE.
  - DONE: v_o=1, key_chain_o stable. yumi_i=1 → IDLE next edge; v_o drops and ready_o rises in the same cycle.
- Latency: v_o is high in the cycle after E52, i.e. 52 cycles after acceptance. Throughput is one key per ≥54 cycles.
- Word rule, for i in 8..59, with t = w[i-1]:
  - i%8==0: t = SubWord(RotWord(t)) ^ {Rcon[i/8],24'h0}; Rcon[1..7] = 01,02,04,08,10,20,40.
  - i%8==4: t = SubWord(t).
  - w[i] = w[i-8] ^ t.
  - RotWord moves the byte in bits [31:24] to bits [7:0].
- Round key r = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in bits [127:96].
- Chain mapping:
  - decrypt flag=0: key_chain_o[r*128 +: 128] = round key r.
  - decrypt flag=1: key_chain_o[r*128 +: 128] = round key 14-r, so slot 0 = round key 14 and slot 14 = cipher key words 0..3.
- Boundaries:
  - key_v_i while not IDLE is ignored; no buffering, key_i is not sampled.
  - yumi_i while v_o=0 is ignored.
  - key_v_i and yumi_i in the same DONE cycle: only yumi_i acts; the key must be re-presented in IDLE.
  - decrypt_i changes after acceptance have no effect.
  - key_chain_o during EXPAND holds partial contents; consumers must not use it.
- Implementation: a single SubWord instance per cycle; no per-word parallel S-boxes.

Decomposition:
- Shared package (aes_pkg):
  - state enum (IDLE/EXPAND/DONE);
  - Rcon constant array;
  - AES_NK=8, AES_NR=14, KEY_CHAIN_W=1920 localparams.
- Sub-module aes_sub_word:
  - 32-bit combinational, four forward S-box lookups;
  - shares the forward S-box table with the encryption sub_bytes.

Test Plan:
- FIPS-197 A.3 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4, decrypt_i=0:
  - v_o rises exactly 52 cycles after the handshake;
  - slot 2 = 9ba35411_8e6925af_a51a8b5f_2067fcde;
  - slot 14 = fe4890d1_e6188d0b_046df344_706c631e;
  - slot 0 = 603deb10_15ca71be_2b73aef0_857d7781.
- Same key, decrypt_i=1:
  - slot 0 = fe4890d1_…_706c631e, slot 12 = 9ba35411_…_2067fcde, slot 14 = 603deb10_…_857d7781;
  - feeding the chain plus the FIPS C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 to aes_decryption yields 00112233445566778899aabbccddeeff.
- Hold yumi_i=0 for 20 cycles in DONE:
  - v_o stays 1 and key_chain_o stays constant;
  - key_v_i pulses are ignored and ready_o stays 0.
- Assert reset_i=0 at counter=30, then release:
  - v_o=0, chain=0, ready_o=1;
  - a new all-zero key expands so that slot 1 = 00000000_00000000_00000000_00000000 and slot 2 = 62636363_62636363_62636363_62636363.
- Back-to-back keys:
  - key_v_i held high continuously with yumi_i=1 whenever v_o=1;
  - each key is accepted in the IDLE cycle after yumi, at a 54-cycle period, with no lost or duplicated chains.
- yumi_i asserted in EXPAND and in IDLE: no state change and no v_o glitch.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule state type and forward S-box.
package aes_pkg;

    localparam int AES_NK      = 8;
    localparam int AES_NR      = 14;
    localparam int KEY_CHAIN_W = 1920;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_e;

    // Index 0 is never used: the schedule only needs Rcon[1..7].
    localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                          8'h08, 8'h10, 8'h20, 8'h40};

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of SBOX, so the bit offset is (255-b)*8.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

endpackage

// File: rtl/aes256_key_schedule_if.sv
// rtl/aes256_key_schedule_if.sv - key/handshake bundle between a key producer and the key schedule.
interface aes256_key_schedule_if;
    import aes_pkg::*;

    logic                   key_v_i;
    logic [255:0]           key_i;
    logic                   decrypt_i;
    logic                   ready_o;
    logic [KEY_CHAIN_W-1:0] key_chain_o;
    logic                   v_o;
    logic                   yumi_i;

    modport master (
        output key_v_i, key_i, decrypt_i, yumi_i,
        input  ready_o, key_chain_o, v_o
    );

    modport slave (
        input  key_v_i, key_i, decrypt_i, yumi_i,
        output ready_o, key_chain_o, v_o
    );
endinterface

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - combinational SubWord: four forward S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {aes_sbox(word[31:24]), aes_sbox(word[23:16]),
                  aes_sbox(word[15:8]),  aes_sbox(word[7:0])};

endmodule

// File: rtl/aes256_key_schedule.sv
// rtl/aes256_key_schedule.sv - sequential AES-256 key expansion, one schedule word per cycle,
// presenting the 15 round keys in encryption or reversed (decryption) order.
module aes256_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUND_KEYS = 15,
    parameter int WORD_W         = 32
) (
    input logic                  clk_i,
    input logic                  reset_i,
    aes256_key_schedule_if.slave bus
);

    localparam int NUM_WORDS = NUM_ROUND_KEYS * 4;

    ks_state_e         state_q, state_d;
    logic [5:0]        cnt_q;
    logic              decrypt_q;
    logic [WORD_W-1:0] w_q [0:NUM_WORDS-1];

    logic              load, step;
    logic [WORD_W-1:0] prev_word, base_word, sub_in, sub_out, t_word;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_v_i) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt_q == 6'(NUM_WORDS - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single shared SubWord; its input is rotated only on the Rcon words.
    assign prev_word = w_q[cnt_q - 6'd1];
    assign base_word = w_q[cnt_q - 6'd8];
    assign sub_in    = (cnt_q[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        t_word = prev_word;
        if (cnt_q[2:0] == 3'd0)      t_word = sub_out ^ {RCON[cnt_q[5:3]], 24'h0};
        else if (cnt_q[2:0] == 3'd4) t_word = sub_out;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decrypt_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                for (int i = 0; i < AES_NK; i++) w_q[i] <= bus.key_i[255-32*i -: 32];
                cnt_q     <= 6'(AES_NK);
                decrypt_q <= bus.decrypt_i;
            end else if (step) begin
                w_q[cnt_q] <= base_word ^ t_word;
                cnt_q      <= cnt_q + 6'd1;
            end
        end
    end

    for (genvar r = 0; r < NUM_ROUND_KEYS; r++) begin : g_slot
        localparam int RF = r;
        localparam int RR = NUM_ROUND_KEYS - 1 - r;
        assign bus.key_chain_o[r*128 +: 128] = decrypt_q
            ? {w_q[4*RR], w_q[4*RR+1], w_q[4*RR+2], w_q[4*RR+3]}
            : {w_q[4*RF], w_q[4*RF+1], w_q[4*RF+2], w_q[4*RF+3]};
    end

    // Held low for the whole reset, independent of the state register.
    assign bus.ready_o = reset_i && (state_q == IDLE);
    assign bus.v_o     = (state_q == DONE);

endmodule

// File: tb/tb_aes256_key_schedule.sv
// tb/tb_aes256_key_schedule.sv - randomized self-checking bench for aes256_key_schedule
// against a GF(2^8)-derived key-expansion model.
module tb_aes256_key_schedule;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    aes256_key_schedule_if bus ();

    aes256_key_schedule dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a ^= 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(logic [255:0] key, logic dec);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [127:0]  rk;
        logic [1919:0] c;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        c = '0;
        for (int r = 0; r < 15; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            if (dec) c[(14-r)*128 +: 128] = rk;
            else     c[r*128 +: 128]      = rk;
        end
        return c;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_chain(string name, logic [1919:0] got, logic [1919:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int s = 14; s >= 0; s--) if (got[s*128 +: 128] !== exp[s*128 +: 128]) bad = s;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s slot %0d got %h expected %h", name, bad,
                     got[bad*128 +: 128], exp[bad*128 +: 128]);
        end
    endtask

    // Transaction-level model: acceptance, 52-cycle expansion, wait for consumer.
    int            phase     = 0;
    int            left      = 0;
    logic [1919:0] exp_chain = '0;
    int            cyc       = 0;
    int            last_acc  = 0;
    int            acc_gap   = 0;
    int            n_acc     = 0;
    int            n_yumi    = 0;

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            phase     = 0;
            exp_chain = '0;
        end else begin
            cyc++;
            case (phase)
                0: if (bus.key_v_i) begin
                    exp_chain = expand(bus.key_i, bus.decrypt_i);
                    phase     = 1;
                    left      = 52;
                    acc_gap   = cyc - last_acc;
                    last_acc  = cyc;
                    n_acc++;
                end
                1: begin
                    left--;
                    if (left == 0) phase = 2;
                end
                default: if (bus.yumi_i) begin
                    phase = 0;
                    n_yumi++;
                end
            endcase
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ready_o", 128'(bus.ready_o), 128'(reset_i && phase == 0));
            chk("v_o", 128'(bus.v_o), 128'(phase == 2));
            if (phase != 1) chk_chain("chain", bus.key_chain_o, exp_chain);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_key(logic [255:0] key, logic dec);
        int n;
        n = 0;
        while (!bus.ready_o && n < 200) begin tick(); n++; end
        chk("ready_wait", 128'(bus.ready_o), 128'd1);
        bus.key_i     = key;
        bus.decrypt_i = dec;
        bus.key_v_i   = 1'b1;
        tick();
        n = 0;
        while (!bus.v_o && n < 100) begin
            bus.key_v_i   = 1'($urandom);
            bus.key_i     = {8{$urandom}};
            bus.decrypt_i = 1'($urandom);
            bus.yumi_i    = 1'($urandom);
            tick();
            n++;
        end
        bus.key_v_i = 1'b0;
        bus.yumi_i  = 1'b0;
        chk("latency", 128'(n), 128'd52);
    endtask

    task automatic hold_and_release(int hold);
        logic [1919:0] snap;
        snap = bus.key_chain_o;
        for (int k = 0; k < hold; k++) begin
            bus.key_v_i = 1'($urandom);
            bus.key_i   = {8{$urandom}};
            tick();
        end
        chk("hold_ready", 128'(bus.ready_o), 128'd0);
        chk_chain("hold_stable", bus.key_chain_o, snap);
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i  = 1'b0;
        bus.key_v_i = 1'b0;
        chk("rel_v", 128'(bus.v_o), 128'd0);
        chk("rel_ready", 128'(bus.ready_o), 128'd1);
    endtask

    initial begin
        int b_acc, b_y, prev_acc, n;
        reset_i       = 1'b0;
        bus.key_v_i   = 1'b0;
        bus.key_i     = '0;
        bus.decrypt_i = 1'b0;
        bus.yumi_i    = 1'b0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_model(8'(i));
        chk("sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("sbox_53", 128'(sb[8'h53]), 128'hed);

        repeat (3) tick();
        chk("rst_ready", 128'(bus.ready_o), 128'd0);
        reset_i = 1'b1;
        #1;
        chk("rst_rel_ready", 128'(bus.ready_o), 128'd1);
        chk("rst_rel_v", 128'(bus.v_o), 128'd0);
        chk_chain("rst_chain", bus.key_chain_o, '0);

        run_key(KEY_A3, 1'b0);
        chk("enc_slot0", bus.key_chain_o[0*128 +: 128], 128'h603deb1015ca71be2b73aef0857d7781);
        chk("enc_slot2", bus.key_chain_o[2*128 +: 128], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("enc_slot14", bus.key_chain_o[14*128 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);
        hold_and_release(20);

        run_key(KEY_A3, 1'b1);
        chk("dec_slot0", bus.key_chain_o[0*128 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("dec_slot12", bus.key_chain_o[12*128 +: 128], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("dec_slot14", bus.key_chain_o[14*128 +: 128], 128'h603deb1015ca71be2b73aef0857d7781);
        hold_and_release(3);

        // Reset with the word counter at 30 (8 after load plus 22 steps).
        bus.key_i   = {8{$urandom}};
        bus.key_v_i = 1'b1;
        tick();
        bus.key_v_i = 1'b0;
        repeat (22) tick();
        reset_i = 1'b0;
        #1;
        chk("mid_rst_v", 128'(bus.v_o), 128'd0);
        chk("mid_rst_ready", 128'(bus.ready_o), 128'd0);
        chk_chain("mid_rst_chain", bus.key_chain_o, '0);
        tick();
        reset_i = 1'b1;
        #1;
        chk("mid_rel_ready", 128'(bus.ready_o), 128'd1);
        chk("mid_rel_v", 128'(bus.v_o), 128'd0);
        chk_chain("mid_rel_chain", bus.key_chain_o, '0);

        run_key('0, 1'b0);
        chk("zero_slot1", bus.key_chain_o[1*128 +: 128], 128'h0);
        chk("zero_slot2", bus.key_chain_o[2*128 +: 128], 128'h62636363626363636263636362636363);
        hold_and_release(1);

        for (int k = 0; k < 3; k++) begin
            run_key({8{$urandom}}, 1'($urandom));
            hold_and_release(int'($urandom_range(0, 5)));
        end

        // Back-to-back: key_v_i held, consumer takes each chain immediately.
        b_acc       = n_acc;
        b_y         = n_yumi;
        prev_acc    = n_acc;
        n           = 0;
        bus.key_v_i = 1'b1;
        while ((n_yumi - b_y) < 4 && n < 400) begin
            bus.key_i     = {8{$urandom}};
            bus.decrypt_i = 1'($urandom);
            tick();
            n++;
            bus.yumi_i = bus.v_o;
            if (n_acc != prev_acc) begin
                if ((n_acc - b_acc) > 1) chk("b2b_period", 128'(acc_gap), 128'd54);
                prev_acc = n_acc;
            end
        end
        bus.key_v_i = 1'b0;
        bus.yumi_i  = 1'b0;
        chk("b2b_yumis", 128'(n_yumi - b_y), 128'd4);
        chk("b2b_accepts", 128'(n_acc - b_acc), 128'd4);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
